// File: rtl/mac_tx_arbiter_pkg.sv
// Shared types and defaults for the MAC transmit arbiter: FSM state encoding
// and the default requester count / inter-frame gap.
`timescale 1ns/1ps
package mac_tx_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_IFG_CYCLES = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from last_grant+1
// (mod N) and returns the first requester found as one-hot and as an index.
`timescale 1ns/1ps
module rr_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    // last_grant <= N-1 and offset <= N, so one conditional subtract is a full mod N.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] last, input int offset);
        int sum;
        sum = int'(last) + offset;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    logic          found;
    logic [IW-1:0] idx;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = rr_index(last_grant_i, k);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Non-preemptive round-robin arbiter that multiplexes whole byte-stream
// frames from NUM_REQ requesters onto one MAC TX input, with an enforced IFG.
`timescale 1ns/1ps
module mac_tx_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int IFG_CYCLES = DEF_IFG_CYCLES,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [NUM_REQ-1:0]      req_enable,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [7:0]              m_data,
    output logic                    m_last,
    output logic                    grant_valid,
    output logic [IW-1:0]           grant_id,
    output logic [15:0]             frames_sent
);

    localparam logic [7:0]    IFG_LOAD   = 8'(IFG_CYCLES);
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQ - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   frames_q, frames_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               xfer_last;

    assign eligible = req_valid & req_enable;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i        (eligible),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_oh),
        .grant_idx_o  (arb_idx)
    );

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_RESET;
            grant_id_q   <= '0;
            gap_q        <= '0;
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            gap_q        <= gap_d;
            frames_q     <= frames_d;
        end
    end

    assign xfer_last = (state_q == ST_XFER) && m_valid && m_ready && m_last;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        gap_d        = gap_q;
        frames_d     = frames_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_oh) begin
                    grant_id_d = arb_idx;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                // Only the final byte of the frame releases the grant.
                if (xfer_last) begin
                    last_grant_d = grant_id_q;
                    frames_d     = frames_q + 16'd1;
                    if (IFG_CYCLES > 0) begin
                        gap_d   = IFG_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        req_ready   = '0;
        grant_valid = 1'b0;
        if (state_q == ST_XFER) begin
            grant_valid           = 1'b1;
            m_valid               = req_valid[grant_id_q];
            m_data                = req_data[grant_id_q];
            m_last                = req_last[grant_id_q];
            req_ready[grant_id_q] = m_ready;
        end
    end

    assign grant_id    = grant_id_q;
    assign frames_sent = frames_q;

endmodule
